dly_tdc_ctrl: RTL and testbench

Digital launch/capture controller that measures the propagation delay of a chain of DLY buffer cells. It fires an edge into the chain head and samples all stage outputs on the following clock edge. The thermometer code is decoded to a stage count, and 2^NAVG_LOG2 samples are averaged. It sits in the digital calibration domain, driving the delay line's input and reading every stage's output.

---
 rtl/dly_tdc_ctrl.sv | 127 ++++++++++++
 tb/tb_dly_tdc_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dly_tdc_ctrl.sv
// Launch/capture controller for a DLY-cell delay chain: fires an edge, samples all taps
// one clock later, decodes the thermometer code and averages 2^NAVG_LOG2 samples.
module dly_tdc_ctrl #(
  parameter int NTAPS     = 32,
  parameter int NAVG_LOG2 = 3,
  parameter int CLR_CYC   = 2,
  parameter int CW        = $clog2(NTAPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NTAPS-1:0] taps,
  output logic             launch,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    result,
  output logic             bubble,
  output logic             sat,
  output logic             zero,
  output logic             stuck
);

  localparam int AW   = CW + NAVG_LOG2;
  localparam int NW   = NAVG_LOG2 + 1;
  localparam int CLRW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam int S    = 1 << NAVG_LOG2;

  typedef enum logic [2:0] {IDLE, LAUNCH, EVAL, CLEAR, DONE} state_t;

  state_t           state;
  logic [NTAPS-1:0] taps_q;
  logic [AW-1:0]    acc;
  logic [NW-1:0]    cnt;
  logic [CLRW-1:0]  clr;

  logic [CW-1:0]    n;
  logic             bub_c;
  logic             seen0;

  // Leading-ones count from tap 0; any 1 after the first 0 is a bubble.
  always_comb begin
    n     = '0;
    bub_c = 1'b0;
    seen0 = 1'b0;
    for (int unsigned i = 0; i < NTAPS; i++) begin
      if (!taps_q[i])  seen0 = 1'b1;
      else if (seen0)  bub_c = 1'b1;
      else             n = n + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      taps_q <= '0;
      acc    <= '0;
      cnt    <= '0;
      clr    <= '0;
      launch <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      bubble <= 1'b0;
      sat    <= 1'b0;
      zero   <= 1'b0;
      stuck  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            bubble <= 1'b0;
            sat    <= 1'b0;
            zero   <= 1'b0;
            stuck  <= 1'b0;
            launch <= 1'b1;
            busy   <= 1'b1;
            state  <= LAUNCH;
          end
        end
        LAUNCH: begin
          taps_q <= taps;
          launch <= 1'b0;
          state  <= EVAL;
        end
        EVAL: begin
          acc <= acc + AW'(n);
          cnt <= cnt + NW'(1);
          if (bub_c)              bubble <= 1'b1;
          if (n == CW'(NTAPS))    sat    <= 1'b1;
          if (n == '0)            zero   <= 1'b1;
          clr   <= '0;
          state <= CLEAR;
        end
        CLEAR: begin
          if (clr == CLRW'(CLR_CYC - 1)) begin
            // The chain must be fully discharged before the next launch.
            if (|taps) begin
              stuck  <= 1'b1;
              result <= '0;
              done   <= 1'b1;
              state  <= DONE;
            end else if (cnt == NW'(S)) begin
              result <= CW'(acc >> NAVG_LOG2);
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              launch <= 1'b1;
              state  <= LAUNCH;
            end
          end else begin
            clr <= clr + CLRW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dly_tdc_ctrl.sv
// Bench for dly_tdc_ctrl: a delay-chain model feeds taps from per-sample patterns and
// results are compared against a plain-arithmetic averaging model.
module tb_dly_tdc_ctrl;

  localparam int NTAPS = 32;
  localparam int CW    = 6;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [NTAPS-1:0] taps;
  logic             launch, busy, done, bubble, sat, zero, stuck;
  logic [CW-1:0]    result;

  int nchk  = 0;
  int nfail = 0;

  logic [31:0] pats [8];
  logic [31:0] idle_val;
  int          pidx;

  always #5 clk = ~clk;

  dly_tdc_ctrl #(.NTAPS(32), .NAVG_LOG2(3), .CLR_CYC(2)) dut (
    .clk(clk), .rst(rst), .start(start), .taps(taps),
    .launch(launch), .busy(busy), .done(done), .result(result),
    .bubble(bubble), .sat(sat), .zero(zero), .stuck(stuck)
  );

  // Chain model: while launch is high the chain shows the next sample pattern,
  // otherwise it shows its resting value (0 when it discharges properly).
  always @(negedge clk) begin
    if (launch === 1'b1) begin
      taps = pats[pidx % 8];
      pidx++;
    end else begin
      taps = idle_val;
    end
  end

  function automatic logic [63:0] lowmask(input int w);
    logic [63:0] one;
    one = 64'd1;
    return (one << w) - 64'd1;
  endfunction

  // Expected {result, bubble, sat, zero, stuck} for a full 8-sample run of pats[].
  function automatic logic [9:0] model();
    int sum;
    bit b, s, z;
    logic [63:0] p;
    int n;
    sum = 0; b = 0; s = 0; z = 0;
    for (int k = 0; k < 8; k++) begin
      p = {32'b0, pats[k]};
      n = 0;
      for (int w = 0; w <= 32; w++)
        if ((p & lowmask(w)) == lowmask(w)) n = w;
      sum += n;
      if ((p >> n) != 64'd0) b = 1;
      if (n == 32) s = 1;
      if (n == 0)  z = 1;
    end
    return {6'(sum / 8), b, s, z, 1'b0};
  endfunction

  function automatic logic [39:0] launch_exp(input int nsamp);
    logic [39:0] v;
    v = '0;
    for (int c = 0; c < 4 * nsamp; c += 4) v[c] = 1'b1;
    return v;
  endfunction

  // Accept one start, then observe 40 cycles (cycle c = c edges after the accepting edge).
  task automatic measure(input bit hold, input int pulse_at, input int rst_at,
                         output int dcyc, output int ndone, output logic [9:0] snap,
                         output logic [39:0] lh, output logic [39:0] bh,
                         output logic [12:0] rsnap);
    dcyc = -1; ndone = 0; snap = '0; lh = '0; bh = '0; rsnap = '1;
    @(negedge clk);
    pidx  = 0;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      lh[c] = launch;
      bh[c] = busy;
      if (done === 1'b1) begin
        ndone++;
        if (dcyc < 0) begin
          dcyc = c;
          snap = {result, bubble, sat, zero, stuck};
        end
      end
      if (rst_at >= 0 && c == rst_at + 1) begin
        rsnap = {launch, busy, done, result, bubble, sat, zero, stuck};
        rst = 1'b0;
      end
      if (rst_at >= 0 && c == rst_at) rst = 1'b1;
      if (!hold) start = (c == pulse_at);
      @(posedge clk); #1;
    end
    if (!hold) start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      nchk++;
      if ({launch, busy, done, result, bubble, sat, zero, stuck} !== 13'b0) begin
        nfail++;
        $display("FAIL reset_outputs cyc%0d: got %b, want 0", i,
                 {launch, busy, done, result, bubble, sat, zero, stuck});
      end
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    for (int k = 0; k < 8; k++) pats[k] = 32'h0000_00FF;
    @(negedge clk); pidx = 0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    nchk++;
    if ({busy, launch} !== 2'b11) begin
      nfail++;
      $display("FAIL reset_first_accept: busy,launch got %b, want 11", {busy, launch});
    end
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic test_uniform();
    int dc, nd; logic [9:0] sn; logic [39:0] lh, bh; logic [12:0] rs;
    for (int k = 0; k < 8; k++) pats[k] = 32'h0000_07FF;
    measure(0, -1, -1, dc, nd, sn, lh, bh, rs);
    nchk++;
    if (dc !== 32 || nd !== 1) begin
      nfail++; $display("FAIL uniform_done: cycle %0d count %0d, want 32 and 1", dc, nd);
    end
    nchk++;
    if (sn !== {6'd11, 4'b0000} || sn !== model()) begin
      nfail++; $display("FAIL uniform_result: got %h, want %h", sn, {6'd11, 4'b0000});
    end
    nchk++;
    if (lh !== launch_exp(8)) begin
      nfail++; $display("FAIL uniform_launch: got %h, want %h", lh, launch_exp(8));
    end
    nchk++;
    if ({result, bubble, sat, zero, stuck} !== sn || busy !== 1'b0) begin
      nfail++; $display("FAIL uniform_hold: got %h busy %b, want %h busy 0",
                        {result, bubble, sat, zero, stuck}, busy, sn);
    end
  endtask

  task automatic test_average();
    int dc, nd; logic [9:0] sn; logic [39:0] lh, bh; logic [12:0] rs;
    int w [8] = '{10, 10, 11, 11, 12, 12, 13, 13};
    for (int k = 0; k < 8; k++) pats[k] = lowmask(w[k]) & 64'hFFFF_FFFF;
    measure(0, -1, -1, dc, nd, sn, lh, bh, rs);
    nchk++;
    if (sn !== {6'd11, 4'b0000}) begin
      nfail++; $display("FAIL average_trunc: got %h, want %h", sn, {6'd11, 4'b0000});
    end
  endtask

  task automatic test_bubble_extremes();
    int dc, nd; logic [9:0] sn; logic [39:0] lh, bh; logic [12:0] rs;
    logic [31:0] pv [3] = '{32'h0000_00F7, 32'hFFFF_FFFF, 32'h0000_0000};
    logic [9:0]  ev [3] = '{{6'd3, 4'b1000}, {6'd32, 4'b0100}, {6'd0, 4'b0010}};
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 8; k++) pats[k] = pv[t];
      measure(0, -1, -1, dc, nd, sn, lh, bh, rs);
      nchk++;
      if (sn !== ev[t] || dc !== 32) begin
        nfail++; $display("FAIL extremes_%0d: got %h at cycle %0d, want %h at 32",
                          t, sn, dc, ev[t]);
      end
    end
  endtask

  task automatic test_random();
    int dc, nd; logic [9:0] sn; logic [39:0] lh, bh; logic [12:0] rs;
    logic [63:0] m;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 8; k++) begin
        m = lowmask($urandom_range(0, 32));
        pats[k] = m[31:0];
        if ($urandom_range(0, 3) == 0) pats[k] = pats[k] | $urandom;
      end
      measure(0, -1, -1, dc, nd, sn, lh, bh, rs);
      nchk++;
      if (sn !== model() || dc !== 32) begin
        nfail++; $display("FAIL random_%0d: got %h at cycle %0d, want %h at 32",
                          r, sn, dc, model());
      end
    end
  endtask

  task automatic test_stuck();
    int dc, nd; logic [9:0] sn; logic [39:0] lh, bh; logic [12:0] rs;
    for (int k = 0; k < 8; k++) pats[k] = 32'h1;
    idle_val = 32'h1;
    measure(0, -1, -1, dc, nd, sn, lh, bh, rs);
    idle_val = 32'h0;
    nchk++;
    if (dc !== 4 || nd !== 1) begin
      nfail++; $display("FAIL stuck_done: cycle %0d count %0d, want 4 and 1", dc, nd);
    end
    nchk++;
    if (sn !== {6'd0, 4'b0001} || lh !== launch_exp(1)) begin
      nfail++; $display("FAIL stuck_result: got %h launch %h, want %h launch %h",
                        sn, lh, {6'd0, 4'b0001}, launch_exp(1));
    end
  endtask

  task automatic test_start_ignored();
    int dc, nd; logic [9:0] sn; logic [39:0] lh, bh; logic [12:0] rs;
    for (int k = 0; k < 8; k++) pats[k] = 32'h0000_3FFF;
    measure(0, 5, -1, dc, nd, sn, lh, bh, rs);
    nchk++;
    if (dc !== 32 || nd !== 1 || lh !== launch_exp(8)) begin
      nfail++; $display("FAIL start_ignored: done cycle %0d count %0d launch %h, want 32 1 %h",
                        dc, nd, lh, launch_exp(8));
    end
    measure(0, 20, -1, dc, nd, sn, lh, bh, rs);
    nchk++;
    if (dc !== 32 || nd !== 1 || bh[39:34] !== 6'b0 || sn !== {6'd14, 4'b0000}) begin
      nfail++; $display("FAIL start_ignored_late: done %0d count %0d busy %b result %h",
                        dc, nd, bh[39:34], sn);
    end
  endtask

  task automatic test_rst_mid();
    int dc, nd; logic [9:0] sn; logic [39:0] lh, bh; logic [12:0] rs;
    for (int k = 0; k < 8; k++) pats[k] = 32'h0000_00F7;
    measure(0, -1, 10, dc, nd, sn, lh, bh, rs);
    nchk++;
    if (rs !== 13'b0) begin
      nfail++; $display("FAIL rst_mid_state: got %b, want 0", rs);
    end
    nchk++;
    if (nd !== 0 || lh[39:11] !== '0 || bh[39:11] !== '0) begin
      nfail++; $display("FAIL rst_mid_quiet: dones %0d launch %h busy %h, want none",
                        nd, lh[39:11], bh[39:11]);
    end
  endtask

  task automatic test_back_to_back();
    int dc, nd; logic [9:0] sn; logic [39:0] lh, bh; logic [12:0] rs;
    bit seen;
    for (int k = 0; k < 8; k++) pats[k] = 32'h000F_FFFF;
    measure(1, -1, -1, dc, nd, sn, lh, bh, rs);
    start = 1'b0;
    nchk++;
    if (dc !== 32 || bh[33] !== 1'b0 || bh[34] !== 1'b1 || lh[34] !== 1'b1) begin
      nfail++; $display("FAIL b2b_restart: done %0d busy33 %b busy34 %b launch34 %b, want 32 0 1 1",
                        dc, bh[33], bh[34], lh[34]);
    end
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (done === 1'b1) begin
        seen = 1;
        sn = {result, bubble, sat, zero, stuck};
      end
      @(posedge clk); #1;
    end
    nchk++;
    if (!seen || sn !== {6'd20, 4'b0000}) begin
      nfail++; $display("FAIL b2b_second: seen %0d result %h, want 1 %h", seen, sn, {6'd20, 4'b0000});
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; taps = '0; idle_val = '0; pidx = 0;
    for (int k = 0; k < 8; k++) pats[k] = '0;
    test_reset();
    test_uniform();
    test_average();
    test_bubble_extremes();
    test_random();
    test_stuck();
    test_start_ignored();
    test_rst_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
